// File: rtl/disp_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller.
package disp_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DRIVE = 2'd1,
    ST_BLANK = 2'd2
  } disp_state_e;

  // Segments and anodes are active-low, so "dark" is all ones.
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

endpackage

// File: rtl/disp_scan_ctrl_hex_code.sv
// Hex nibble to active-low 7-segment glyph (bits 6..0 = g..a).
module hex_code (
  input  logic [3:0] nib,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = 7'h7F;
    unique case (nib)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
      default: seg_n = 7'h7F;
    endcase
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-synchronous value update.
// Optional leading-zero blanking when DISP_LZ_BLANK_EN is defined.
module disp_scan_ctrl
  import disp_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [7:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int DW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CMAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] DRV_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);

  disp_state_e                 state;
  logic [CW-1:0]               cnt;
  logic [DW-1:0]               dig;
  logic [NUM_DIGITS-1:0][3:0]  staging;
  logic [NUM_DIGITS-1:0][3:0]  shadow;
  logic                        drv_tc;
  logic                        boundary;
  logic [3:0]                  sel_nib;
  logic [6:0]                  glyph_n;
  logic                        lz_blank;

  // One counter serves both the drive period and the dead gap.
  assign drv_tc   = (state == ST_DRIVE) && (cnt == DRV_LAST);
  assign boundary = en && drv_tc && (dig == DIG_LAST);
  assign frame_done = boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_OFF;
      cnt   <= '0;
      dig   <= '0;
    end else if (!en) begin
      state <= ST_OFF;
      cnt   <= '0;
      dig   <= '0;
    end else begin
      unique case (state)
        ST_OFF: begin
          state <= ST_DRIVE;
          cnt   <= '0;
          dig   <= '0;
        end
        ST_DRIVE: begin
          if (drv_tc) begin
            state <= ST_BLANK;
            cnt   <= '0;
            dig   <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BLANK: begin
          if (cnt == BLK_LAST) begin
            state <= ST_DRIVE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_OFF;
          cnt   <= '0;
          dig   <= '0;
        end
      endcase
    end
  end

  // Shadow only changes at the wrap, so a frame never mixes two values;
  // a load landing on the wrap cycle bypasses staging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging <= '0;
      shadow  <= '0;
    end else begin
      if (load)     staging <= value;
      if (boundary) shadow  <= load ? value : staging;
    end
  end

  assign sel_nib = shadow[dig];

  hex_code u_hex (
    .nib   (sel_nib),
    .seg_n (glyph_n)
  );

`ifdef DISP_LZ_BLANK_EN
  // Blank digit i>0 when it and every more-significant nibble are zero.
  always_comb begin
    lz_blank = (dig != '0);
    for (int j = 0; j < NUM_DIGITS; j++)
      if ((j >= int'(dig)) && (shadow[j] != 4'h0)) lz_blank = 1'b0;
  end
`else
  assign lz_blank = 1'b0;
`endif

  // Gating with en darkens the outputs on the same edge the FSM drops to OFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n <= SEG_OFF;
      an_n  <= AN_OFF[NUM_DIGITS-1:0];
    end else if (en && (state == ST_DRIVE)) begin
      seg_n <= {~dp_mask[dig], (lz_blank ? 7'h7F : glyph_n)};
      an_n  <= ~(NUM_DIGITS'(1) << dig);
    end else begin
      seg_n <= SEG_OFF;
      an_n  <= AN_OFF[NUM_DIGITS-1:0];
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl (4 digits, 4-cycle drive, 1-cycle gap).
module tb_disp_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_mask;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int n_chk  = 0;
  int n_pass = 0;
  int n;

`ifdef DISP_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  disp_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .DEAD_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .value      (value),
    .load       (load),
    .dp_mask    (dp_mask),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_fd(input int budget, output int cnt);
    cnt = 0;
    step();
    cnt++;
    while (!frame_done && cnt < budget) begin
      step();
      cnt++;
    end
  endtask

  // Called right after a frame_done sample; walks the next 20 cycles.
  task automatic check_frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3, input logic [7:0] prev3,
                             input int la, input logic [15:0] va,
                             input int lb, input logic [15:0] vb, input logic [3:0] dpb);
    logic [7:0] segs [4];
    logic [3:0] ea;
    logic [7:0] es;
    int p;
    segs = '{s0, s1, s2, s3};
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) begin
        ea = 4'b0111;
        es = prev3;
      end else begin
        p = k - 2;
        if (p % 5 == 0) begin
          ea = 4'hF;
          es = 8'hFF;
        end else begin
          ea = ~(4'b0001 << (p / 5));
          es = segs[p / 5];
        end
      end
      chk($sformatf("%s_an_k%0d", tag, k), 32'(an_n), 32'(ea));
      chk($sformatf("%s_seg_k%0d", tag, k), 32'(seg_n), 32'(es));
      chk($sformatf("%s_fd_k%0d", tag, k), 32'(frame_done), 32'(k == 20));
      if (k == la) begin value = va; load = 1'b1; end
      if (k == lb) begin value = vb; load = 1'b1; dp_mask = dpb; end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; value = '0; dp_mask = '0;
    step(); step();
    chk("rst_an", 32'(an_n), 32'hF);
    chk("rst_seg", 32'(seg_n), 32'hFF);
    chk("rst_fd", 32'(frame_done), 32'h0);

    rst_n = 1'b1;
    step(); step();
    chk("off_an", 32'(an_n), 32'hF);
    chk("off_seg", 32'(seg_n), 32'hFF);
    chk("off_fd", 32'(frame_done), 32'h0);

    // First frame still shows the zero shadow; 12AF arrives at its end.
    en = 1'b1; value = 16'h12AF; load = 1'b1;
    wait_fd(40, n);
    chk("first_fd_lat", 32'(n), 32'd19);

    check_frame("f12AF", 8'h8E, 8'h88, 8'hA4, 8'hF9, 8'hC0,
                7, 16'h1234, 12, 16'h5678, 4'b0000);
    check_frame("f5678", 8'h80, 8'hF8, 8'h82, 8'h92, 8'hF9,
                -1, 16'h0, 20, 16'h0050, 4'b1000);
    check_frame("f0050", 8'hC0, 8'h92, LZ ? 8'hFF : 8'hC0, LZ ? 8'h7F : 8'h40, 8'h12,
                -1, 16'h0, -1, 16'h0, 4'b1000);

    // Drop en while digit 2 is being driven.
    for (int k = 1; k <= 13; k++) step();
    chk("d2_an", 32'(an_n), 32'b1011);
    chk("d2_seg", 32'(seg_n), LZ ? 32'hFF : 32'hC0);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("endrop_an%0d", k), 32'(an_n), 32'hF);
      chk($sformatf("endrop_seg%0d", k), 32'(seg_n), 32'hFF);
      chk($sformatf("endrop_fd%0d", k), 32'(frame_done), 32'h0);
    end
    en = 1'b1;
    step();
    chk("resume_dark", 32'(an_n), 32'hF);
    step();
    chk("resume_an", 32'(an_n), 32'b1110);
    chk("resume_seg", 32'(seg_n), 32'hC0);
    wait_fd(40, n);
    chk("resume_fd_lat", 32'(n), 32'd17);

    // Asynchronous reset while a digit is lit.
    step(); step(); step();
    chk("prerst_an", 32'(an_n), 32'b1110);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_an", 32'(an_n), 32'hF);
    chk("arst_seg", 32'(seg_n), 32'hFF);
    chk("arst_fd", 32'(frame_done), 32'h0);
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) step();
    chk("postrst_an", 32'(an_n), 32'b1101);
    chk("postrst_seg", 32'(seg_n), LZ ? 32'hFF : 32'hC0);
    wait_fd(40, n);
    chk("postrst_fd_lat", 32'(n), 32'd12);
    check_frame("fzero", 8'hC0, LZ ? 8'hFF : 8'hC0, LZ ? 8'hFF : 8'hC0,
                LZ ? 8'h7F : 8'h40, LZ ? 8'h7F : 8'h40,
                -1, 16'h0, -1, 16'h0, 4'b1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 8, the number of multiplexed 7-segment digits (range 1..8).
REQ-002 The block SHALL have parameter REFRESH_DIV, default 50000, the number of clk cycles each digit is driven (minimum 2).
REQ-003 The block SHALL have parameter DEAD_CYCLES, default 16, the all-off anti-ghosting gap between digits (minimum 1).
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset; one clock (clk), reset asynchronous and active-low, as fixed for this block.
REQ-006 en  input  1  scan enable; 0 turns the display dark.
REQ-007 value  input  4*NUM_DIGITS  hex word to display; nibble i is shown on digit i.
REQ-008 load  input  1  single-cycle strobe that captures value.
REQ-009 dp_mask  input  NUM_DIGITS  decimal point enables, active-high, bit i for digit i.
REQ-010 seg_n  output  8  active-low segments: bit 7 = DP, bits 6..0 = g..a.
REQ-011 an_n  output  NUM_DIGITS  active-low digit anodes; at most one bit low at any time.
REQ-012 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 The FSM SHALL have states OFF, DRIVE and BLANK.
REQ-014 OFF: an_n all 1, seg_n 8'hFF, prescaler 0, digit index 0; on en=1 go to DRIVE at digit 0.
REQ-015 DRIVE: prescaler counts 0..REFRESH_DIV-1; at terminal count go to BLANK and advance digit index, wrapping NUM_DIGITS-1 to 0.
REQ-016 BLANK: an_n all 1 and seg_n 8'hFF for exactly DEAD_CYCLES cycles, then DRIVE.
REQ-017 en=0 in any state SHALL force OFF on the next edge, abandoning the current digit.
REQ-018 The driven pattern SHALL be the standard hex glyph set (0..9, A, b, C, d, E, F) of shadow nibble [4i+3:4i], with seg_n[7] = ~dp_mask[i].
REQ-019 seg_n and an_n SHALL be registered; the output cycle reflects state and digit index of the previous cycle (latency 1).
REQ-020 load SHALL write value into a staging register; staging SHALL transfer to the shadow register only at a frame boundary (digit index wrapping to 0), so a frame never shows mixed values.
REQ-021 Load coinciding with the boundary cycle: the new value SHALL go directly to the shadow register.
REQ-022 Multiple loads within one frame: the last one wins.
REQ-023 frame_done SHALL pulse on the boundary cycle, including when NUM_DIGITS=1; it SHALL not pulse in OFF.
REQ-024 dp_mask SHALL be sampled live (not shadowed).

Reset
REQ-025 On rst_n=0: state OFF, an_n all 1, seg_n 8'hFF, frame_done 0, prescaler 0, digit 0, staging and shadow 0.
REQ-026 Reset release SHALL take effect on the first clk edge after deassertion; reset mid-scan SHALL darken outputs immediately (asynchronously).

Configuration
REQ-027 Macro DISP_LZ_BLANK_EN defined: in DRIVE, digit i>0 whose nibble and all higher nibbles are zero SHALL drive seg_n[6:0]=7'h7F (DP per dp_mask, anode still asserted); digit 0 is never blanked.
REQ-028 Macro undefined: every digit shows its glyph, including leading zeros.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the SEG_OFF constant (8'hFF) and the AN_OFF all-ones convention.
REQ-030 Glyph lookup SHALL be one instance of the team's hex-to-segment decoder hex_code per block, fed by the selected nibble; no second sub-module.

Verification (bench: NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1)
REQ-031 Reset, en=1, load value=16'h12AF -> after the first boundary, an_n cycles 1110,1111,1101,1111,1011,1111,0111,1111 with 4-cycle drives/1-cycle gaps and seg_n 8'h8E,8'h88,8'hA4,8'hF9.
REQ-032 Load 16'h1234 mid-frame, then 16'h5678 in the same frame -> the current frame is unchanged; the next frame shows 5678 only; frame_done pulses once per 20 cycles.
REQ-033 Load coinciding with frame_done -> that frame already shows the new value on digit 0.
REQ-034 en dropped during DRIVE of digit 2 -> next cycle state OFF, outputs dark next cycle; en re-raised -> digit 0 resumes.
REQ-035 With DISP_LZ_BLANK_EN, value 16'h0050, dp_mask 4'b1000 -> digit 3 seg_n 8'h7F, digit 2 8'hFF, digit 1 8'h92, digit 0 8'hC0; without the macro, digits 3 and 2 show 8'h40 and 8'hC0.
REQ-036 rst_n asserted mid-DRIVE -> an_n all 1 and seg_n 8'hFF with no clk edge; no anode is ever low during BLANK.
